// File: rtl/fetch_unit.sv
// Sequential instruction fetch: owns the PC, issues one outstanding word-aligned
// request at a time and delivers each returned instruction through a one-entry slot.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int unsigned INST_BYTES = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]      state_q,      state_d;
    logic [XLEN-1:0] pc_q,         pc_d;
    logic [XLEN-1:0] req_pc_q,     req_pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] inst_data_q,  inst_data_d;
    logic [XLEN-1:0] inst_pc_q,    inst_pc_d;

    logic slot_free;
    logic req_hs;

    // Request side is combinational so a slot freed this cycle can fetch immediately.
    always_comb begin
        slot_free      = !inst_valid_q || inst_ready;
        imem_req_valid = (state_q == S_REQ) && slot_free;
        imem_req_addr  = pc_q;
        req_hs         = imem_req_valid && imem_req_ready;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;

        if (inst_valid_q && inst_ready) begin
            inst_valid_d = 1'b0;
        end

        if (state_q == S_IDLE) begin
            state_d = S_REQ;
        end else if (redirect_valid) begin
            // Anything already accepted by memory is stale and must be drained.
            pc_d         = {redirect_pc[XLEN-1:2], 2'b00};
            inst_valid_d = 1'b0;
            case (state_q)
                S_REQ:   state_d = req_hs ? S_DRAIN : S_REQ;
                default: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_hs) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + XLEN'(INST_BYTES);
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        inst_valid_d = 1'b1;
                        inst_data_d  = imem_rsp_data;
                        inst_pc_d    = req_pc_q;
                        state_d      = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rsp_valid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a latency-configurable memory and a
// transaction-level model (outstanding flag, generation/live bit, slot) predict every output.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    int checks = 0;
    int errors = 0;

    // stimulus knobs (percent probabilities, memory latency range)
    int          p_rdy = 100, p_inst = 100, p_redir = 0, k_min = 1, k_max = 1;
    bit          hold_rdy_low = 1'b0;
    bit          force_redir = 1'b0;
    logic [31:0] force_tgt = '0;

    // memory model: single outstanding request
    bit          mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    // reference model
    bit          m_started, m_out, m_live, m_sv;
    logic [31:0] m_pc, m_oaddr, m_sd, m_spc;

    function automatic bit chance(int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_out     = 1'b0;
        m_live    = 1'b0;
        m_sv      = 1'b0;
        m_pc      = RST_PC;
        m_oaddr   = '0;
        m_sd      = '0;
        m_spc     = '0;
    endtask

    task automatic check_reset_values();
        chk1 ("rst_req_valid",  imem_req_valid, 1'b0);
        chk32("rst_req_addr",   imem_req_addr,  RST_PC);
        chk1 ("rst_inst_valid", inst_valid,     1'b0);
        chk32("rst_inst_data",  inst_data,      32'h0);
        chk32("rst_inst_pc",    inst_pc,        32'h0);
    endtask

    // One clock: drive inputs at negedge, check outputs, advance memory and model at posedge.
    task automatic cycle();
        bit          exp_rv, hs, rsp_eff, dut_hs, rdir;
        logic [31:0] dut_addr, tgt;
        @(negedge clk);
        imem_req_ready = hold_rdy_low ? 1'b0 : chance(p_rdy);
        inst_ready     = chance(p_inst);
        rdir           = force_redir || chance(p_redir);
        tgt            = force_redir ? force_tgt : $urandom;
        redirect_valid = rdir;
        redirect_pc    = tgt;
        force_redir    = 1'b0;
        imem_rsp_valid = mem_pend && (mem_cnt == 0);
        imem_rsp_data  = imem_rsp_valid ? (mem_addr ^ KEY) : $urandom;
        #1;
        exp_rv = m_started && !m_out && (!m_sv || inst_ready);
        chk1 ("req_valid",  imem_req_valid, exp_rv);
        chk32("req_addr",   imem_req_addr,  m_pc);
        chk1 ("inst_valid", inst_valid,     m_sv);
        if (m_sv) begin
            chk32("inst_data", inst_data, m_sd);
            chk32("inst_pc",   inst_pc,   m_spc);
        end
        hs       = exp_rv && imem_req_ready;
        rsp_eff  = m_out && imem_rsp_valid;
        dut_hs   = imem_req_valid && imem_req_ready;
        dut_addr = imem_req_addr;
        @(posedge clk);
        if (imem_rsp_valid) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (dut_hs) begin
            mem_pend = 1'b1;
            mem_cnt  = int'($urandom_range(k_max, k_min)) - 1;
            mem_addr = dut_addr;
        end
        if (!m_started) begin
            m_started = 1'b1;
        end else begin
            if (m_sv && inst_ready) m_sv = 1'b0;
            if (rsp_eff) begin
                m_out = 1'b0;
                if (m_live && !rdir) begin
                    m_sv  = 1'b1;
                    m_sd  = m_oaddr ^ KEY;
                    m_spc = m_oaddr;
                end
            end
            if (hs) begin
                m_out   = 1'b1;
                m_live  = 1'b1;
                m_oaddr = m_pc;
                m_pc    = m_pc + 32'd4;
            end
            if (rdir) begin
                m_pc   = tgt & 32'hFFFF_FFFC;
                m_sv   = 1'b0;
                m_live = 1'b0;
            end
        end
    endtask

    task automatic set_knobs(input int rdy, input int ins, input int rd, input int kmin, input int kmax);
        p_rdy = rdy; p_inst = ins; p_redir = rd; k_min = kmin; k_max = kmax;
    endtask

    initial begin
        bit reached;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_values();
        @(posedge clk);
        #2 rst_n = 1'b1;

        // streaming with k=1, wraps past 0xFFFF_FFFC right away
        set_knobs(100, 100, 0, 1, 1);
        repeat (20) cycle();
        // decode back-pressure
        set_knobs(100, 30, 0, 1, 2);
        repeat (60) cycle();
        // memory back-pressure
        set_knobs(40, 100, 0, 1, 3);
        repeat (60) cycle();

        // directed: redirect to an unaligned target while a k=3 request is outstanding
        set_knobs(100, 100, 0, 3, 3);
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            cycle();
            reached = m_out && mem_pend && (mem_cnt == 2);
        end
        chk1("wait_reached", reached, 1'b1);
        force_redir = 1'b1;
        force_tgt   = 32'h0000_1003;
        repeat (12) cycle();

        // mixed random traffic with redirects
        set_knobs(60, 60, 8, 1, 4);
        repeat (1500) cycle();

        // asynchronous reset while a slow response is outstanding
        set_knobs(100, 100, 0, 5, 5);
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            cycle();
            reached = m_out && mem_pend && (mem_cnt >= 3);
        end
        chk1("reset_setup", reached, 1'b1);
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        if (mem_pend) mem_cnt--;
        #2 rst_n = 1'b1;
        hold_rdy_low = 1'b1;
        for (int i = 0; i < 20 && mem_pend; i++) cycle();
        chk1("late_rsp_seen", mem_pend, 1'b0);
        hold_rdy_low = 1'b0;

        set_knobs(70, 70, 5, 1, 3);
        repeat (300) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
